// File: rtl/apb_uart_pkg.sv
// Shared register map, bit positions and bus widths for the APB UART FIFO bridge.
package apb_uart_pkg;

    localparam int unsigned DATA_BUS_W = 32;

    typedef enum logic [2:0] {
        REG_CTRL      = 3'd0,
        REG_STATUS    = 3'd1,
        REG_TXDATA    = 3'd2,
        REG_RXDATA    = 3'd3,
        REG_BAUDDIV   = 3'd4,
        REG_RX_THRESH = 3'd5,
        REG_IRQ_EN    = 3'd6,
        REG_IRQ_STAT  = 3'd7
    } reg_idx_e;

    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_STATUS    = 8'h04;
    localparam logic [7:0] OFF_TXDATA    = 8'h08;
    localparam logic [7:0] OFF_RXDATA    = 8'h0C;
    localparam logic [7:0] OFF_BAUDDIV   = 8'h10;
    localparam logic [7:0] OFF_RX_THRESH = 8'h14;
    localparam logic [7:0] OFF_IRQ_EN    = 8'h18;
    localparam logic [7:0] OFF_IRQ_STAT  = 8'h1C;

    localparam int unsigned CTRL_TX_EN    = 0;
    localparam int unsigned CTRL_RX_EN    = 1;
    localparam int unsigned CTRL_TX_FLUSH = 2;
    localparam int unsigned CTRL_RX_FLUSH = 3;

    localparam int unsigned STAT_TX_FULL  = 0;
    localparam int unsigned STAT_TX_EMPTY = 1;
    localparam int unsigned STAT_RX_FULL  = 2;
    localparam int unsigned STAT_RX_EMPTY = 3;
    localparam int unsigned STAT_TX_BUSY  = 4;

    localparam int unsigned IRQ_TX_EMPTY  = 0;
    localparam int unsigned IRQ_RX_THRESH = 1;
    localparam int unsigned IRQ_RX_OVR    = 2;
    localparam int unsigned IRQ_RX_FERR   = 3;

endpackage

// File: rtl/apb_uart_fifo_bridge_if.sv
// APB3 request/response bundle with master and slave views.
interface apb_uart_fifo_bridge_if
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) ();
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_BUS_W-1:0] PWDATA;
    logic [DATA_BUS_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_uart_fifo_bridge_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flush overrides push and pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push_c, do_pop_c;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop_c  = pop & ~empty & ~flush;
        do_push_c = push & (~full | pop) & ~flush;
        wr_ptr_d  = wr_ptr_q + LW'(do_push_c);
        rd_ptr_d  = rd_ptr_q + LW'(do_pop_c);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/apb_uart_fifo_bridge.sv
// APB register front-end for the UART cores: TX/RX FIFOs, baud divisor, sticky errors, interrupt.
module apb_uart_fifo_bridge
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned TX_DEPTH     = 16,
    parameter int unsigned RX_DEPTH     = 16,
    parameter int unsigned BAUD_W       = 16,
    parameter int unsigned BAUD_DIV_RST = 651
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_uart_fifo_bridge_if.slave apb,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic                 tx_busy,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_frame_err,
    output logic                 tx_en,
    output logic                 rx_en,
    output logic [BAUD_W-1:0]    baud_div,
    output logic                 irq
);
    localparam int unsigned TX_LW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_LW = $clog2(RX_DEPTH) + 1;

    logic [1:0]            ctrl_q, ctrl_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [7:0]            thresh_q, thresh_d;
    logic [3:0]            irq_en_q, irq_en_d;
    logic                  ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;

    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [TX_LW-1:0]      tx_level;
    logic [RX_LW-1:0]      rx_level;
    logic [DATA_BITS-1:0]  rx_head;

    logic                  access_c, addr_ok_c, thresh_hit_c;
    reg_idx_e              idx_c;
    logic                  tx_push_c, tx_pop_c, tx_flush_c;
    logic                  rx_push_c, rx_pop_c, rx_flush_c;
    logic [3:0]            w1c_c, irq_stat_c;
    logic [DATA_BUS_W-1:0] status_c, prdata_c;
    logic                  pslverr_c;
    logic                  unused_c;

    assign access_c  = apb.PSEL & apb.PENABLE;
    assign addr_ok_c = (apb.PADDR[ADDR_WIDTH-1:5] == '0);
    assign idx_c     = reg_idx_e'(apb.PADDR[4:2]);
    assign unused_c  = ^{apb.PWDATA[DATA_BUS_W-1:BAUD_W], apb.PADDR[1:0]};

    assign tx_en       = ctrl_q[CTRL_TX_EN];
    assign rx_en       = ctrl_q[CTRL_RX_EN];
    assign baud_div    = baud_q;
    assign irq         = irq_q;
    assign tx_valid    = tx_en & ~tx_empty;
    assign tx_pop_c    = tx_valid & tx_ready;
    assign rx_push_c   = rx_valid & rx_en;
    assign apb.PREADY  = 1'b1;
    assign apb.PRDATA  = prdata_c;
    assign apb.PSLVERR = pslverr_c;

    always_comb begin
        status_c                = '0;
        status_c[STAT_TX_FULL]  = tx_full;
        status_c[STAT_TX_EMPTY] = tx_empty;
        status_c[STAT_RX_FULL]  = rx_full;
        status_c[STAT_RX_EMPTY] = rx_empty;
        status_c[STAT_TX_BUSY]  = tx_busy;
        status_c[15:8]          = 8'(tx_level);
        status_c[23:16]         = 8'(rx_level);
        thresh_hit_c            = (thresh_q != 8'd0) && (8'(rx_level) >= thresh_q);
        irq_stat_c                = '0;
        irq_stat_c[IRQ_TX_EMPTY]  = tx_empty;
        irq_stat_c[IRQ_RX_THRESH] = thresh_hit_c;
        irq_stat_c[IRQ_RX_OVR]    = ovr_q;
        irq_stat_c[IRQ_RX_FERR]   = ferr_q;
    end

    // Register decode: combinational response plus the side effects committed at the access edge.
    always_comb begin
        prdata_c   = '0;
        pslverr_c  = 1'b0;
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        thresh_d   = thresh_q;
        irq_en_d   = irq_en_q;
        tx_push_c  = 1'b0;
        rx_pop_c   = 1'b0;
        tx_flush_c = 1'b0;
        rx_flush_c = 1'b0;
        w1c_c      = '0;
        if (access_c) begin
            if (!addr_ok_c) begin
                pslverr_c = 1'b1;
            end else begin
                case (idx_c)
                    REG_CTRL: begin
                        if (apb.PWRITE) begin
                            ctrl_d     = apb.PWDATA[1:0];
                            tx_flush_c = apb.PWDATA[CTRL_TX_FLUSH];
                            rx_flush_c = apb.PWDATA[CTRL_RX_FLUSH];
                        end else prdata_c = DATA_BUS_W'(ctrl_q);
                    end
                    REG_STATUS: if (!apb.PWRITE) prdata_c = status_c;
                    REG_TXDATA: begin
                        if (!apb.PWRITE || (tx_full && !tx_pop_c)) pslverr_c = 1'b1;
                        else tx_push_c = 1'b1;
                    end
                    REG_RXDATA: begin
                        if (apb.PWRITE || rx_empty) pslverr_c = 1'b1;
                        else begin
                            prdata_c = DATA_BUS_W'(rx_head);
                            rx_pop_c = 1'b1;
                        end
                    end
                    REG_BAUDDIV: begin
                        if (!apb.PWRITE) prdata_c = DATA_BUS_W'(baud_q);
                        else if (apb.PWDATA[BAUD_W-1:0] == '0) pslverr_c = 1'b1;
                        else baud_d = apb.PWDATA[BAUD_W-1:0];
                    end
                    REG_RX_THRESH: begin
                        if (apb.PWRITE) thresh_d = apb.PWDATA[7:0];
                        else prdata_c = DATA_BUS_W'(thresh_q);
                    end
                    REG_IRQ_EN: begin
                        if (apb.PWRITE) irq_en_d = apb.PWDATA[3:0];
                        else prdata_c = DATA_BUS_W'(irq_en_q);
                    end
                    REG_IRQ_STAT: begin
                        if (apb.PWRITE) w1c_c = apb.PWDATA[3:0];
                        else prdata_c = DATA_BUS_W'(irq_stat_c);
                    end
                    default: pslverr_c = 1'b1;
                endcase
            end
        end
    end

    // Sticky flags: a set event in the clearing cycle wins.
    always_comb begin
        ovr_d  = (ovr_q & ~w1c_c[IRQ_RX_OVR]) | (rx_push_c & rx_full & ~rx_pop_c);
        ferr_d = (ferr_q & ~w1c_c[IRQ_RX_FERR]) | (rx_push_c & rx_frame_err);
        irq_d  = |(irq_stat_c & irq_en_q);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q   <= '0;
            baud_q   <= BAUD_W'(BAUD_DIV_RST);
            thresh_q <= '0;
            irq_en_q <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            baud_q   <= baud_d;
            thresh_q <= thresh_d;
            irq_en_q <= irq_en_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            irq_q    <= irq_d;
        end
    end

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (tx_push_c),
        .pop   (tx_pop_c),
        .flush (tx_flush_c),
        .wdata (apb.PWDATA[DATA_BITS-1:0]),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (rx_push_c),
        .pop   (rx_pop_c),
        .flush (rx_flush_c),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );
endmodule
